// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder: scan-code prefixes,
// prefix-FSM state encodings, queue entry width and a parity helper.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Queue entry layout: {ext, brk, code[7:0]}
   localparam int EVT_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } prefix_state_t;

   // PS/2 uses odd parity: the data bits plus the parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A push and a pop in the same
// cycle both take effect even when full; pushes to a full FIFO without a
// pop and pops from an empty FIFO are ignored.
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             empty_s;
   logic             full_s;
   logic             rd_ok_s;
   logic             wr_ok_s;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign rd_ok_s = rd_en && !empty_s;
   assign wr_ok_s = wr_en && (!full_s || rd_ok_s);

   assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
   assign empty   = empty_s;
   assign full    = full_s;

   // Storage and pointer update; a write into the slot being popped is safe
   // because the read side consumes the old value in the same cycle.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
            wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (rd_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: synchronises the raw PS/2 lines, frames bytes,
// folds E0/F0 prefixes into events, queues them, and tracks key presses.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic             i_ps2_clk,
   input  logic             i_ps2_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [7:0]       o_code,
   output logic             o_ext,
   output logic             o_break,
   output logic             o_overflow,
   output logic             o_frame_err,
   output logic [CNT_W-1:0] o_key_count,
   output logic             o_key_held
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   // Synchroniser and edge detection
   logic [1:0]       clk_sync_r;
   logic [1:0]       data_sync_r;
   logic [2:0]       clk_hist_r;
   logic             fall_s;

   // Framer
   logic [3:0]       bit_idx_r;
   logic [9:0]       shift_r;
   logic [TO_W-1:0]  to_cnt_r;
   logic             frame_ok_s;
   logic             byte_vld_r;
   logic [7:0]       byte_r;
   logic             frame_err_r;

   // Prefix FSM and event generation
   prefix_state_t    state_r;
   logic             push_s;
   logic             push_ext_s;
   logic             push_brk_s;

   // Queue side
   logic [EVT_W-1:0] head_s;
   logic             fifo_empty_s;
   logic             fifo_full_s;
   logic             pop_ok_s;
   logic             overflow_r;

   // Key tracking
   logic [CNT_W-1:0] key_count_r;
   logic             key_held_r;
   logic [8:0]       rec_key_r;

   assign fall_s     = (clk_hist_r == 3'b110);
   assign frame_ok_s = (shift_r[0] == 1'b0) && (data_sync_r[1] == 1'b1) &&
                       odd_parity_ok(shift_r[8:1], shift_r[9]);

   // Two-flop synchronisers plus a short history of the synchronised clock.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         clk_sync_r  <= 2'b00;
         data_sync_r <= 2'b00;
         clk_hist_r  <= 3'b000;
      end else begin
         clk_sync_r  <= {clk_sync_r[0], i_ps2_clk};
         data_sync_r <= {data_sync_r[0], i_ps2_data};
         clk_hist_r  <= {clk_hist_r[1:0], clk_sync_r[1]};
      end
   end

   // Frame assembly: shift start/data/parity, judge the frame on the stop bit,
   // and abandon a partial frame if the PS/2 clock goes quiet too long.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         bit_idx_r   <= 4'd0;
         shift_r     <= 10'd0;
         to_cnt_r    <= '0;
         byte_vld_r  <= 1'b0;
         byte_r      <= 8'd0;
         frame_err_r <= 1'b0;
      end else begin
         byte_vld_r  <= 1'b0;
         frame_err_r <= 1'b0;
         if (fall_s) begin
            to_cnt_r <= '0;
            if (bit_idx_r == 4'd10) begin
               bit_idx_r <= 4'd0;
               if (frame_ok_s) begin
                  byte_vld_r <= 1'b1;
                  byte_r     <= shift_r[8:1];
               end else begin
                  frame_err_r <= 1'b1;
               end
            end else begin
               shift_r   <= {data_sync_r[1], shift_r[9:1]};
               bit_idx_r <= bit_idx_r + 4'd1;
            end
         end else if (bit_idx_r != 4'd0) begin
            if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
               bit_idx_r <= 4'd0;
               to_cnt_r  <= '0;
            end else begin
               to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            end
         end else begin
            to_cnt_r <= '0;
         end
      end
   end

   // Turn a non-prefix byte into an event flavoured by the pending prefixes.
   always_comb begin
      push_s     = 1'b0;
      push_ext_s = 1'b0;
      push_brk_s = 1'b0;
      if (byte_vld_r && (byte_r != PS2_EXT) && (byte_r != PS2_BRK)) begin
         push_s = 1'b1;
         case (state_r)
            ST_IDLE:    begin push_ext_s = 1'b0; push_brk_s = 1'b0; end
            ST_EXT:     begin push_ext_s = 1'b1; push_brk_s = 1'b0; end
            ST_BRK:     begin push_ext_s = 1'b0; push_brk_s = 1'b1; end
            ST_EXT_BRK: begin push_ext_s = 1'b1; push_brk_s = 1'b1; end
            default:    begin push_ext_s = 1'b0; push_brk_s = 1'b0; end
         endcase
      end else begin
         push_s = 1'b0;
      end
   end

   // Prefix FSM: E0 always restarts an extended sequence, F0 marks a release.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         state_r <= ST_IDLE;
      end else if (byte_vld_r) begin
         if (byte_r == PS2_EXT) begin
            state_r <= ST_EXT;
         end else if (byte_r == PS2_BRK) begin
            case (state_r)
               ST_IDLE:    state_r <= ST_BRK;
               ST_EXT:     state_r <= ST_EXT_BRK;
               ST_BRK:     state_r <= ST_BRK;
               ST_EXT_BRK: state_r <= ST_EXT_BRK;
               default:    state_r <= ST_IDLE;
            endcase
         end else begin
            state_r <= ST_IDLE;
         end
      end
   end

   assign pop_ok_s = i_pop && !fifo_empty_s;

   sync_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (i_clk),
      .clr_n   (i_clr_n),
      .wr_en   (push_s),
      .wr_data ({push_ext_s, push_brk_s, byte_r}),
      .rd_en   (pop_ok_s),
      .rd_data (head_s),
      .empty   (fifo_empty_s),
      .full    (fifo_full_s)
   );

   // Sticky overflow: set by a dropped push, cleared by the next real pop.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         overflow_r <= 1'b0;
      end else if (push_s && fifo_full_s && !pop_ok_s) begin
         overflow_r <= 1'b1;
      end else if (pop_ok_s) begin
         overflow_r <= 1'b0;
      end
   end

   // Key-press tracking; typematic repeats of the held key are not counted.
   // Runs on every generated event, whether or not the queue accepted it.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         key_count_r <= '0;
         key_held_r  <= 1'b0;
         rec_key_r   <= 9'd0;
      end else if (push_s && !push_brk_s) begin
         if (!key_held_r || (rec_key_r != {push_ext_s, byte_r})) begin
            key_count_r <= key_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            rec_key_r   <= {push_ext_s, byte_r};
            key_held_r  <= 1'b1;
         end
      end else if (push_s && push_brk_s) begin
         if (key_held_r && (rec_key_r == {push_ext_s, byte_r})) begin
            key_held_r <= 1'b0;
         end
      end
   end

   assign o_valid     = !fifo_empty_s;
   assign o_code      = fifo_empty_s ? 8'h00 : head_s[7:0];
   assign o_ext       = fifo_empty_s ? 1'b0  : head_s[9];
   assign o_break     = fifo_empty_s ? 1'b0  : head_s[8];
   assign o_overflow  = overflow_r;
   assign o_frame_err = frame_err_r;
   assign o_key_count = key_count_r;
   assign o_key_held  = key_held_r;

endmodule
